// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared types and constants for the retire stage
//   XLEN, PRF_SIZE, PRF_IDX_W : datapath widths
//   ROB_PACKET                : one ROB entry as presented at the ROB head
//   RETIRE_PACKET             : one committed slot (valid, adest, t_new, t_old)
//   RETIRE_STATE              : retire FSM states
package sys_defs;

    localparam int XLEN      = 32;
    localparam int PRF_SIZE  = 64;
    localparam int PRF_IDX_W = $clog2(PRF_SIZE);

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [4:0]           adest;
        logic [PRF_IDX_W-1:0] t_new;
        logic [PRF_IDX_W-1:0] t_old;
        logic                 is_branch;
        logic                 predict_take_branch;
        logic                 ex_take_branch;
        logic [XLEN-1:0]      predict_target_pc;
        logic [XLEN-1:0]      ex_target_pc;
        logic                 rd_mem_violation;
        logic                 halt;
        logic                 illegal;
    } ROB_PACKET;

    typedef struct packed {
        logic                 valid;
        logic [4:0]           adest;
        logic [PRF_IDX_W-1:0] t_new;
        logic [PRF_IDX_W-1:0] t_old;
    } RETIRE_PACKET;

    typedef enum logic [1:0] {
        RS_RUN,
        RS_FLUSH,
        RS_DRAIN,
        RS_HALTED
    } RETIRE_STATE;

endpackage

// File: rtl/br_resolve_check.sv
// rtl/br_resolve_check.sv - combinational mispredict detect and redirect PC for one ROB entry
//   in  : is_branch, predict/ex take flags, pc, predict/ex target PCs
//   out : mispred, recover_pc (ex target when taken, else pc+4 truncated to XLEN)
module br_resolve_check
    import sys_defs::*;
(
    input  logic            is_branch,
    input  logic            predict_take_branch,
    input  logic            ex_take_branch,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] predict_target_pc,
    input  logic [XLEN-1:0] ex_target_pc,
    output logic            mispred,
    output logic [XLEN-1:0] recover_pc
);

    // Target mismatch only matters when the branch was actually taken.
    assign mispred = is_branch &&
                     ((ex_take_branch != predict_take_branch) ||
                      (ex_take_branch && (ex_target_pc != predict_target_pc)));

    assign recover_pc = ex_take_branch ? ex_target_pc : pc + XLEN'(4);

endmodule

// File: rtl/retire_stage.sv
// rtl/retire_stage.sv - in-order 2-wide commit stage with flush/drain and halt handling
//   clock, reset (sync active-high)
//   rob_packet_in[1:0], head_retire_rdy, head_p1_retire_rdy : ROB head and head+1
//   retire_valid, free_preg, arch_wr_adest, arch_wr_preg     : registered commit outputs
//   flush, recover_pc                                        : one-cycle squash and redirect
//   halt, illegal_err                                        : sticky stop flags
//   retired_cnt                                              : committed instruction count
//   RETIRE_STATS_EN : when defined adds branch_cnt and mispred_cnt outputs
module retire_stage
    import sys_defs::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_WIDTH    = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  ROB_PACKET [1:0]           rob_packet_in,
    input  logic                      head_retire_rdy,
    input  logic                      head_p1_retire_rdy,
    output logic [1:0]                retire_valid,
    output logic [1:0][PRF_IDX_W-1:0] free_preg,
    output logic [1:0][4:0]           arch_wr_adest,
    output logic [1:0][PRF_IDX_W-1:0] arch_wr_preg,
    output logic                      flush,
    output logic [XLEN-1:0]           recover_pc,
    output logic                      halt,
    output logic                      illegal_err,
`ifdef RETIRE_STATS_EN
    output logic [CNT_WIDTH-1:0]      branch_cnt,
    output logic [CNT_WIDTH-1:0]      mispred_cnt,
`endif
    output logic [CNT_WIDTH-1:0]      retired_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    RETIRE_STATE     state, next_state;
    logic [DW-1:0]   drain_cnt, next_drain_cnt;

    logic [1:0]      mispred;
    logic [1:0][XLEN-1:0] br_pc;

    RETIRE_PACKET [1:0] commit_pkt;
    logic            redirect;
    logic            redirect_mispred;
    logic [XLEN-1:0] redirect_pc;
    logic            go_halt;
    logic            go_illegal;

    for (genvar i = 0; i < 2; i++) begin : g_br
        br_resolve_check u_br (
            .is_branch           (rob_packet_in[i].is_branch),
            .predict_take_branch (rob_packet_in[i].predict_take_branch),
            .ex_take_branch      (rob_packet_in[i].ex_take_branch),
            .pc                  (rob_packet_in[i].pc),
            .predict_target_pc   (rob_packet_in[i].predict_target_pc),
            .ex_target_pc        (rob_packet_in[i].ex_target_pc),
            .mispred             (mispred[i]),
            .recover_pc          (br_pc[i])
        );
    end

    // Walk the two head slots oldest-first; the first redirect or stop ends the walk
    // so nothing younger than it can commit.
    always_comb begin
        commit_pkt       = '0;
        redirect         = 1'b0;
        redirect_mispred = 1'b0;
        redirect_pc      = '0;
        go_halt          = 1'b0;
        go_illegal       = 1'b0;
        if (state == RS_RUN && head_retire_rdy && rob_packet_in[0].valid) begin
            if (rob_packet_in[0].rd_mem_violation) begin
                redirect    = 1'b1;
                redirect_pc = rob_packet_in[0].pc;
            end else begin
                commit_pkt[0] = '{1'b1, rob_packet_in[0].adest, rob_packet_in[0].t_new, rob_packet_in[0].t_old};
                if (rob_packet_in[0].halt || rob_packet_in[0].illegal) begin
                    go_halt    = 1'b1;
                    go_illegal = rob_packet_in[0].illegal;
                end else if (mispred[0]) begin
                    redirect         = 1'b1;
                    redirect_mispred = 1'b1;
                    redirect_pc      = br_pc[0];
                end else if (head_p1_retire_rdy && rob_packet_in[1].valid) begin
                    if (rob_packet_in[1].rd_mem_violation) begin
                        redirect    = 1'b1;
                        redirect_pc = rob_packet_in[1].pc;
                    end else begin
                        commit_pkt[1] = '{1'b1, rob_packet_in[1].adest, rob_packet_in[1].t_new, rob_packet_in[1].t_old};
                        if (rob_packet_in[1].halt || rob_packet_in[1].illegal) begin
                            go_halt    = 1'b1;
                            go_illegal = rob_packet_in[1].illegal;
                        end else if (mispred[1]) begin
                            redirect         = 1'b1;
                            redirect_mispred = 1'b1;
                            redirect_pc      = br_pc[1];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        next_state     = state;
        next_drain_cnt = drain_cnt;
        case (state)
            RS_RUN: begin
                if (go_halt) begin
                    next_state = RS_HALTED;
                end else if (redirect) begin
                    next_state = RS_FLUSH;
                end
            end
            RS_FLUSH: begin
                next_state     = RS_DRAIN;
                next_drain_cnt = '0;
            end
            RS_DRAIN: begin
                if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
                    next_state = RS_RUN;
                end else begin
                    next_drain_cnt = drain_cnt + DW'(1);
                end
            end
            default: next_state = RS_HALTED;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RS_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= next_state;
            drain_cnt <= next_drain_cnt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            retire_valid  <= '0;
            free_preg     <= '0;
            arch_wr_adest <= '0;
            arch_wr_preg  <= '0;
            flush         <= 1'b0;
            recover_pc    <= '0;
            halt          <= 1'b0;
            illegal_err   <= 1'b0;
            retired_cnt   <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                retire_valid[i]  <= commit_pkt[i].valid;
                free_preg[i]     <= commit_pkt[i].t_old;
                arch_wr_adest[i] <= commit_pkt[i].adest;
                arch_wr_preg[i]  <= commit_pkt[i].t_new;
            end
            flush       <= redirect;
            recover_pc  <= redirect_pc;
            halt        <= halt | go_halt;
            illegal_err <= illegal_err | go_illegal;
            retired_cnt <= retired_cnt + CNT_WIDTH'(commit_pkt[0].valid)
                                       + CNT_WIDTH'(commit_pkt[1].valid);
        end
    end

`ifdef RETIRE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            branch_cnt  <= branch_cnt
                           + CNT_WIDTH'(commit_pkt[0].valid & rob_packet_in[0].is_branch)
                           + CNT_WIDTH'(commit_pkt[1].valid & rob_packet_in[1].is_branch);
            mispred_cnt <= mispred_cnt + CNT_WIDTH'(redirect_mispred);
        end
    end
`endif

endmodule

// File: tb/tb_retire_stage.sv
// tb/tb_retire_stage.sv - randomized bench for retire_stage against a slot-walking reference model
module tb_retire_stage;
    import sys_defs::*;

    localparam int DRAIN = 2;
    localparam int CW    = 64;

    logic                      clock;
    logic                      reset;
    ROB_PACKET [1:0]           pkts;
    logic                      r0, r1;
    logic [1:0]                retire_valid;
    logic [1:0][PRF_IDX_W-1:0] free_preg;
    logic [1:0][4:0]           arch_wr_adest;
    logic [1:0][PRF_IDX_W-1:0] arch_wr_preg;
    logic                      flush;
    logic [XLEN-1:0]           recover_pc;
    logic                      halt;
    logic                      illegal_err;
    logic [CW-1:0]             retired_cnt;
`ifdef RETIRE_STATS_EN
    logic [CW-1:0]             branch_cnt;
    logic [CW-1:0]             mispred_cnt;
`endif

    retire_stage #(.DRAIN_CYCLES(DRAIN), .CNT_WIDTH(CW)) dut (
        .clock              (clock),
        .reset              (reset),
        .rob_packet_in      (pkts),
        .head_retire_rdy    (r0),
        .head_p1_retire_rdy (r1),
        .retire_valid       (retire_valid),
        .free_preg          (free_preg),
        .arch_wr_adest      (arch_wr_adest),
        .arch_wr_preg       (arch_wr_preg),
        .flush              (flush),
        .recover_pc         (recover_pc),
        .halt               (halt),
        .illegal_err        (illegal_err),
`ifdef RETIRE_STATS_EN
        .branch_cnt         (branch_cnt),
        .mispred_cnt        (mispred_cnt),
`endif
        .retired_cnt        (retired_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int              m_block;
    bit              m_halted;
    logic [1:0]      e_valid;
    logic [5:0]      e_free [2];
    logic [4:0]      e_adest [2];
    logic [5:0]      e_preg [2];
    logic            e_flush;
    logic [31:0]     e_pc;
    logic            e_halt, e_ill;
    longint unsigned e_cnt, e_br, e_mis;

    function automatic bit is_mispred(input ROB_PACKET p);
        if (!p.is_branch) return 1'b0;
        if (p.ex_take_branch != p.predict_take_branch) return 1'b1;
        return p.ex_take_branch && (p.ex_target_pc != p.predict_target_pc);
    endfunction

    // Expected outputs after the coming edge, from the inputs currently driven.
    task automatic model_step();
        e_valid = 2'b00;
        e_flush = 1'b0;
        e_pc    = '0;
        if (reset) begin
            m_block = 0; m_halted = 0;
            e_halt = 0; e_ill = 0; e_cnt = 0; e_br = 0; e_mis = 0;
            return;
        end
        if (m_halted) return;
        if (m_block > 0) begin
            m_block--;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            ROB_PACKET p;
            bit rdy;
            p   = pkts[i];
            rdy = (i == 0) ? r0 : r1;
            if (!rdy || !p.valid) break;
            if (p.rd_mem_violation) begin
                e_flush = 1'b1; e_pc = p.pc; m_block = 1 + DRAIN;
                break;
            end
            e_valid[i] = 1'b1;
            e_free[i]  = p.t_old;
            e_adest[i] = p.adest;
            e_preg[i]  = p.t_new;
            e_cnt++;
            if (p.is_branch) e_br++;
            if (p.halt || p.illegal) begin
                m_halted = 1; e_halt = 1;
                if (p.illegal) e_ill = 1;
                break;
            end
            if (is_mispred(p)) begin
                e_flush = 1'b1;
                e_pc    = p.ex_take_branch ? p.ex_target_pc : p.pc + 32'd4;
                m_block = 1 + DRAIN;
                e_mis++;
                break;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check("retire_valid", retire_valid, e_valid);
        for (int i = 0; i < 2; i++) begin
            if (e_valid[i]) begin
                check($sformatf("free_preg[%0d]", i), free_preg[i], e_free[i]);
                check($sformatf("arch_wr_adest[%0d]", i), arch_wr_adest[i], e_adest[i]);
                check($sformatf("arch_wr_preg[%0d]", i), arch_wr_preg[i], e_preg[i]);
            end
        end
        check("flush", flush, e_flush);
        if (e_flush) check("recover_pc", recover_pc, e_pc);
        check("halt", halt, e_halt);
        check("illegal_err", illegal_err, e_ill);
        check("retired_cnt", retired_cnt, e_cnt);
`ifdef RETIRE_STATS_EN
        check("branch_cnt", branch_cnt, e_br);
        check("mispred_cnt", mispred_cnt, e_mis);
`endif
    endtask

    // kind: 0 clean, 1 branch, 2 halt, 3 illegal, 4 violation, 5 bubble
    function automatic ROB_PACKET mk(input int kind);
        ROB_PACKET p;
        p       = '0;
        p.valid = (kind != 5);
        p.pc    = 32'($urandom_range(0, 1023)) << 2;
        p.adest = 5'($urandom);
        p.t_new = 6'($urandom);
        p.t_old = 6'($urandom);
        if (kind == 1) begin
            p.is_branch           = 1'b1;
            p.predict_take_branch = 1'($urandom);
            p.ex_take_branch      = 1'($urandom);
            p.predict_target_pc   = 32'h100 + 32'($urandom_range(0, 1)) * 4;
            p.ex_target_pc        = 32'h100 + 32'($urandom_range(0, 1)) * 4;
        end
        p.halt             = (kind == 2);
        p.illegal          = (kind == 3);
        p.rd_mem_violation = (kind == 4);
        return p;
    endfunction

    function automatic int rand_kind();
        int r;
        r = $urandom_range(0, 99);
        if (r < 50) return 0;
        if (r < 75) return 1;
        if (r < 76) return 2;
        if (r < 77) return 3;
        if (r < 87) return 4;
        return 5;
    endfunction

    initial begin
        reset = 1'b1;
        r0 = 1'b0; r1 = 1'b0;
        pkts = '0;
        cycle();
        cycle();
        reset = 1'b0;

        // 1: two clean entries
        pkts[0] = mk(0); pkts[1] = mk(0); r0 = 1; r1 = 1;
        cycle();
        check("t1_valid_11", retire_valid, 2'b11);
        check("t1_cnt_2", retired_cnt, 64'd2);

        // 2: slot1 not ready, slot0 adest 0
        pkts[0] = mk(0); pkts[0].adest = 5'd0; pkts[1] = mk(0); r1 = 0;
        cycle();
        check("t2_valid_01", retire_valid, 2'b01);

        // 3: slot0 mispredict NT -> taken 0x100
        pkts[0] = mk(0);
        pkts[0].is_branch = 1; pkts[0].predict_take_branch = 0;
        pkts[0].ex_take_branch = 1; pkts[0].ex_target_pc = 32'h100;
        pkts[1] = mk(0); r1 = 1;
        cycle();
        check("t3_flush", flush, 1'b1);
        check("t3_recover_pc", recover_pc, 32'h100);
        pkts[0] = mk(0); pkts[1] = mk(0);
        for (int k = 0; k < 5; k++) cycle();

        // 4: slot1 load-order violation at 0x40
        pkts[0] = mk(0); pkts[1] = mk(4); pkts[1].pc = 32'h40;
        cycle();
        check("t4_valid_01", retire_valid, 2'b01);
        check("t4_recover_pc", recover_pc, 32'h40);
        pkts[0] = mk(0); pkts[1] = mk(0);
        for (int k = 0; k < 5; k++) cycle();

        // 5: slot0 halt, slot1 mispredict
        pkts[0] = mk(2);
        pkts[1] = mk(1); pkts[1].predict_take_branch = 0; pkts[1].ex_take_branch = 1;
        cycle();
        check("t5_halt", halt, 1'b1);
        check("t5_no_flush", flush, 1'b0);
        pkts[0] = mk(0); pkts[1] = mk(0);
        for (int k = 0; k < 3; k++) cycle();
        reset = 1;
        cycle();
        reset = 0;
        check("t5_halt_cleared", halt, 1'b0);

        // 6: reset during drain
        pkts[0] = mk(4);
        cycle();
        pkts[0] = mk(0);
        cycle();
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        pkts[0] = mk(0); pkts[1] = mk(0); r1 = 0;
        cycle();
        check("t6_commit_after_reset", retire_valid, 2'b01);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            pkts[0] = mk(rand_kind());
            pkts[1] = mk(rand_kind());
            r0 = ($urandom_range(0, 9) < 8);
            r1 = ($urandom_range(0, 9) < 7);
            reset = ($urandom_range(0, 99) < 2) || (m_halted && $urandom_range(0, 9) == 0);
            cycle();
        end
        reset = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
